// File: rtl/alu_issue_if.sv
// alu_issue_if
//  Bundles the two valid/ready channels around the ALU issue decoder:
//  the instruction-in channel (in_*) and the decoded-entry-out channel (out_*).
//  Handshake rule for both channels: a transfer happens on a rising clock
//  edge where valid && ready are both high; the sender holds its payload
//  stable while valid && !ready.
//  Modports:
//    master : the environment side (drives instructions, consumes entries)
//    slave  : the decoder side (accepts instructions, presents entries)
interface alu_issue_if;
  // instruction-in channel
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] in_rs1_val;
  logic [31:0] in_rs2_val;
  // decoded-entry-out channel
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [3:0]  out_ctrl;
  logic [4:0]  out_rd;
  logic        out_we;
  logic        out_branch;
  logic [2:0]  out_funct3;
  logic        out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, in_rs1_val, in_rs2_val, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_ctrl, out_rd, out_we,
           out_branch, out_funct3, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, in_rs1_val, in_rs2_val, out_ready,
    output in_ready, out_valid, out_a, out_b, out_ctrl, out_rd, out_we,
           out_branch, out_funct3, out_illegal
  );
endinterface

// File: rtl/alu_issue_decoder.sv
// alu_issue_decoder
//  Decodes RV32I instructions plus their register operands into ALU operands
//  and a 4-bit ALU ctrl code, and issues them to execute through a 2-entry
//  skid buffer (one instruction per cycle sustained under backpressure).
//  Optional feature macro: ALU_ILLEGAL_TRAP_EN. When defined, unsupported
//  encodings issue with out_illegal=1; otherwise they issue as a silent NOP
//  and out_illegal is constant 0.
//  Ports:
//    clk, rst_n   clock (rising edge), asynchronous active-low reset
//    flush        synchronous flush: drops buffered entries and the input
//                 offered in the same cycle
//    bus          alu_issue_if.slave: in_* instruction channel, out_* entry
//                 channel, valid/ready on both
//    issue_count  wrapping count of out-channel handshakes (CNT_W bits)
module alu_issue_decoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  alu_issue_if.slave       bus,
  output logic [CNT_W-1:0] issue_count
);

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLT  = 4'b0001;
  localparam logic [3:0] ALU_SLTU = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_OR   = 4'b0100;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_SUB  = 4'b1011;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic [4:0]  rd;
    logic        we;
    logic        branch;
    logic [2:0]  funct3;
    logic        illegal;
  } entry_t;

  // funct3 -> ctrl for OP / OP-IMM; alt selects SUB (funct3 000) or SRA (101).
  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
    logic [3:0] c;
    case (f3)
      3'b000:  c = alt ? ALU_SUB : ALU_ADD;
      3'b001:  c = ALU_SLL;
      3'b010:  c = ALU_SLT;
      3'b011:  c = ALU_SLTU;
      3'b100:  c = ALU_XOR;
      3'b101:  c = alt ? ALU_SRA : ALU_SRL;
      3'b110:  c = ALU_OR;
      default: c = ALU_AND;
    endcase
    return c;
  endfunction

  // ---------------------------------------------------------------- decode
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_u;
  logic        bad;
  entry_t      dec;

  assign instr  = bus.in_instr;
  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_u  = {instr[31:12], 12'b0};

  // rs1 index bits are not needed: operand values arrive already read.
  logic unused_rs1_idx;
  assign unused_rs1_idx = ^instr[19:15];

  always_comb begin
    dec        = '0;
    bad        = 1'b0;
    dec.rd     = instr[11:7];
    dec.funct3 = f3;
    dec.ctrl   = ALU_ADD;
    case (opcode)
      OPC_OP: begin
        dec.a  = bus.in_rs1_val;
        dec.b  = bus.in_rs2_val;
        dec.we = 1'b1;
        if (funct7 == 7'b0000000)      dec.ctrl = alu_op(f3, 1'b0);
        else if (funct7 == 7'b0100000) dec.ctrl = alu_op(f3, 1'b1);
        else                           bad      = 1'b1;
      end
      OPC_OP_IMM: begin
        dec.a  = bus.in_rs1_val;
        dec.we = 1'b1;
        if (f3 == 3'b001 || f3 == 3'b101) begin
          // shifts take the 5-bit shamt, not the sign-extended immediate
          dec.b    = {27'b0, instr[24:20]};
          dec.ctrl = alu_op(f3, (f3 == 3'b101) && instr[30]);
        end else begin
          // instr[30] is immediate data here, so never select SUB
          dec.b    = imm_i;
          dec.ctrl = alu_op(f3, 1'b0);
        end
      end
      OPC_LUI: begin
        dec.b  = imm_u;
        dec.we = 1'b1;
      end
      OPC_AUIPC: begin
        dec.a  = bus.in_pc;
        dec.b  = imm_u;
        dec.we = 1'b1;
      end
      OPC_LOAD: begin
        dec.a  = bus.in_rs1_val;
        dec.b  = imm_i;
        dec.we = 1'b1;
      end
      OPC_STORE: begin
        dec.a = bus.in_rs1_val;
        dec.b = imm_s;
      end
      OPC_BRANCH: begin
        dec.a      = bus.in_rs1_val;
        dec.b      = bus.in_rs2_val;
        dec.branch = 1'b1;
        case (f3[2:1])
          2'b10:   dec.ctrl = ALU_SLT;   // BLT / BGE
          2'b11:   dec.ctrl = ALU_SLTU;  // BLTU / BGEU
          default: dec.ctrl = ALU_SUB;   // BEQ / BNE
        endcase
      end
      default: bad = 1'b1;
    endcase

    // Unsupported encodings still occupy an issue slot, as an ADD 0+0 with
    // no writeback, so ordering downstream is preserved.
    if (bad) begin
      dec.a      = '0;
      dec.b      = '0;
      dec.ctrl   = ALU_ADD;
      dec.we     = 1'b0;
      dec.branch = 1'b0;
`ifdef ALU_ILLEGAL_TRAP_EN
      dec.illegal = 1'b1;
`else
      dec.illegal = 1'b0;
`endif
    end

    if (dec.rd == 5'd0) dec.we = 1'b0;
  end

  // ----------------------------------------------------------- skid buffer
  entry_t           mem_q [2];
  entry_t           mem_d [2];
  logic [1:0]       count_q, count_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push;
  logic             pop;
  entry_t           head;

  // A flush cycle suppresses both handshakes: the offered input is dropped
  // and the head entry is discarded rather than counted as issued.
  assign push = bus.in_valid && in_ready_q && !flush;
  assign pop  = (count_q != 2'd0) && bus.out_ready && !flush;

  always_comb begin
    mem_d    = mem_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (pop) cnt_d = cnt_q + CNT_W'(1);
    if (flush) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = dec;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
    // Registered ready: reflects the occupancy the buffer will have next cycle.
    in_ready_d = (count_d != 2'd2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      in_ready_q <= 1'b1;
      cnt_q      <= '0;
    end else begin
      mem_q[0]   <= mem_d[0];
      mem_q[1]   <= mem_d[1];
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      in_ready_q <= in_ready_d;
      cnt_q      <= cnt_d;
    end
  end

  assign head            = mem_q[rd_ptr_q];
  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = (count_q != 2'd0);
  assign bus.out_a       = head.a;
  assign bus.out_b       = head.b;
  assign bus.out_ctrl    = head.ctrl;
  assign bus.out_rd      = head.rd;
  assign bus.out_we      = head.we;
  assign bus.out_branch  = head.branch;
  assign bus.out_funct3  = head.funct3;
  assign bus.out_illegal = head.illegal;
  assign issue_count     = cnt_q;

endmodule

// File: tb/tb_alu_issue_decoder.sv
// tb_alu_issue_decoder
//  Directed bench for alu_issue_decoder. Expected entries are pushed into
//  exp_q when an input handshake completes; an independent monitor pops and
//  compares on every output handshake. A small counter model tracks
//  issue_count (CNT_W reduced to 3 so wrap-around is reached quickly).
module tb_alu_issue_decoder;
  localparam int CNT_W = 3;
  localparam int EW    = 79;
`ifdef ALU_ILLEGAL_TRAP_EN
  localparam logic TRAP = 1'b1;
`else
  localparam logic TRAP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic [CNT_W-1:0] issue_count;

  alu_issue_if bus ();

  alu_issue_decoder #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .bus         (bus.slave),
    .issue_count (issue_count)
  );

  // ------------------------------------------------------- clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------------------------------------------------- scoreboard
  logic [EW-1:0]    exp_q[$];
  logic [CNT_W-1:0] exp_cnt = '0;
  int               errors = 0;
  int               checks = 0;
  logic             stream_mode = 1'b0;
  int               ready_drops = 0;
  logic [EW-1:0]    out_pk;

  assign out_pk = {bus.out_a, bus.out_b, bus.out_ctrl, bus.out_rd, bus.out_we,
                   bus.out_branch, bus.out_funct3, bus.out_illegal};

  function automatic logic [EW-1:0] pk(input logic [31:0] a, input logic [31:0] b,
                                       input logic [3:0] ctrl, input logic [4:0] rd,
                                       input logic we, input logic br,
                                       input logic [2:0] f3, input logic ill);
    return {a, b, ctrl, rd, we, br, f3, ill};
  endfunction

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [EW-1:0] e;
    if (rst_n && bus.out_valid && bus.out_ready && !flush) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got %h expected no entry", out_pk);
      end else begin
        e = exp_q.pop_front();
        check("out_entry", {1'b0, out_pk}, {1'b0, e});
      end
      exp_cnt = exp_cnt + 1'b1;
    end
  end

  always @(negedge clk) if (stream_mode && !bus.in_ready) ready_drops++;

  // ------------------------------------------------------------- drivers
  task automatic push(input logic [31:0] instr, input logic [31:0] pc,
                      input logic [31:0] rs1, input logic [31:0] rs2,
                      input logic [EW-1:0] exp);
    int n = 0;
    bus.in_valid   = 1'b1;
    bus.in_instr   = instr;
    bus.in_pc      = pc;
    bus.in_rs1_val = rs1;
    bus.in_rs2_val = rs2;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < 50);
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: in_ready=0 expected 1 within 50 cycles");
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    exp_q.push_back(exp);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || bus.out_valid) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: pending=%0d expected 0", exp_q.size());
    end
  endtask

  // ------------------------------------------------------------ stimulus
  logic [CNT_W-1:0] base_cnt;
  logic [EW-1:0]    exp_a;

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_instr   = '0;
    bus.in_pc      = '0;
    bus.in_rs1_val = '0;
    bus.in_rs2_val = '0;
    bus.out_ready  = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_issue_count", issue_count, 0);
    check("rst_out_data", out_pk, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // directed decode vectors, streaming with out_ready=1
    bus.out_ready = 1'b1;
    stream_mode   = 1'b1;
    push(32'h002081B3, 32'h0, 32'd15, 32'd10, pk(32'd15, 32'd10, 4'b0000, 5'd3, 1, 0, 3'b000, 0));
    check("latency_valid", bus.out_valid, 1);
    push(32'h40435293, 32'h0, 32'h80000000, 32'h1234,
         pk(32'h80000000, 32'd4, 4'b1010, 5'd5, 1, 0, 3'b101, 0));
    push(32'h0020E463, 32'h0, 32'd1, 32'd2, pk(32'd1, 32'd2, 4'b0010, 5'd8, 0, 1, 3'b110, 0));
    push(32'h402081B3, 32'h0, 32'd20, 32'd7, pk(32'd20, 32'd7, 4'b1011, 5'd3, 1, 0, 3'b000, 0));
    push(32'h123450B7, 32'h0, 32'hDEAD, 32'hBEEF,
         pk(32'h0, 32'h12345000, 4'b0000, 5'd1, 1, 0, 3'b101, 0));
    push(32'h00001117, 32'h100, 32'h5, 32'h6, pk(32'h100, 32'h1000, 4'b0000, 5'd2, 1, 0, 3'b001, 0));
    push(32'hFFC0A203, 32'h0, 32'h1000, 32'h9,
         pk(32'h1000, 32'hFFFFFFFC, 4'b0000, 5'd4, 1, 0, 3'b010, 0));
    push(32'h0020A423, 32'h0, 32'h2000, 32'h77, pk(32'h2000, 32'd8, 4'b0000, 5'd8, 0, 0, 3'b010, 0));
    push(32'hFFF00393, 32'h0, 32'h0, 32'h3, pk(32'h0, 32'hFFFFFFFF, 4'b0000, 5'd7, 1, 0, 3'b000, 0));
    push(32'h00208033, 32'h0, 32'd5, 32'd6, pk(32'd5, 32'd6, 4'b0000, 5'd0, 0, 0, 3'b000, 0));
    push(32'h00208463, 32'h0, 32'd3, 32'd3, pk(32'd3, 32'd3, 4'b1011, 5'd8, 0, 1, 3'b000, 0));
    push(32'h0020D463, 32'h0, 32'd4, 32'd9, pk(32'd4, 32'd9, 4'b0001, 5'd8, 0, 1, 3'b101, 0));
    push(32'h0020C1B3, 32'h0, 32'hF0, 32'h0F, pk(32'hF0, 32'h0F, 4'b0011, 5'd3, 1, 0, 3'b100, 0));
    push(32'h002091B3, 32'h0, 32'h1, 32'h21, pk(32'h1, 32'h21, 4'b1000, 5'd3, 1, 0, 3'b001, 0));
    push(32'h00435293, 32'h0, 32'h80, 32'h0, pk(32'h80, 32'd4, 4'b1001, 5'd5, 1, 0, 3'b101, 0));
    push(32'h000001FF, 32'h0, 32'h11, 32'h22, pk(32'h0, 32'h0, 4'b0000, 5'd3, 0, 0, 3'b000, TRAP));
    push(32'h022081B3, 32'h0, 32'h11, 32'h22, pk(32'h0, 32'h0, 4'b0000, 5'd3, 0, 0, 3'b000, TRAP));
    wait_drain();
    stream_mode = 1'b0;
    check("stream_no_stall", ready_drops, 0);
    check("stream_issue_count", issue_count, exp_cnt);

    // backpressure: two entries fill the buffer, third waits
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    base_cnt = issue_count;
    exp_a = pk(32'd1, 32'd2, 4'b0000, 5'd3, 1, 0, 3'b000, 0);
    push(32'h002081B3, 32'h0, 32'd1, 32'd2, exp_a);
    push(32'h002081B3, 32'h0, 32'd3, 32'd4, pk(32'd3, 32'd4, 4'b0000, 5'd3, 1, 0, 3'b000, 0));
    check("full_in_ready_low", bus.in_ready, 0);
    fork
      push(32'h402081B3, 32'h0, 32'd9, 32'd5, pk(32'd9, 32'd5, 4'b1011, 5'd3, 1, 0, 3'b000, 0));
      begin
        repeat (3) @(posedge clk);
        #1;
        check("full_hold_ready", bus.in_ready, 0);
        check("stall_out_stable", out_pk, exp_a);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_drain", bus.in_ready, 1);
      end
    join
    wait_drain();
    check("bp_issue_plus3", issue_count, base_cnt + 3'd3);
    check("bp_issue_model", issue_count, exp_cnt);

    // flush with two entries buffered, plus an input offered in the flush cycle
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    push(32'h002081B3, 32'h0, 32'd7, 32'd8, pk(32'd7, 32'd8, 4'b0000, 5'd3, 1, 0, 3'b000, 0));
    push(32'h0020C1B3, 32'h0, 32'd7, 32'd8, pk(32'd7, 32'd8, 4'b0011, 5'd3, 1, 0, 3'b100, 0));
    base_cnt = issue_count;
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h002081B3;
    flush = 1'b1;
    @(posedge clk);
    exp_q.delete();
    #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_out_valid", bus.out_valid, 0);
    check("flush_in_ready", bus.in_ready, 1);
    check("flush_issue_count", issue_count, base_cnt);
    bus.out_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("flush_input_dropped", bus.out_valid, 0);
    check("flush_count_after", issue_count, base_cnt);
    @(posedge clk);
    #1;
    push(32'h0020E463, 32'h0, 32'd6, 32'd5, pk(32'd6, 32'd5, 4'b0010, 5'd8, 0, 1, 3'b110, 0));
    wait_drain();
    check("post_flush_count", issue_count, exp_cnt);

    // reset in the middle of a transfer
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    push(32'h002081B3, 32'h0, 32'd1, 32'd1, pk(32'd1, 32'd1, 4'b0000, 5'd3, 1, 0, 3'b000, 0));
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_in_ready", bus.in_ready, 1);
    check("midrst_issue_count", issue_count, 0);
    check("midrst_out_data", out_pk, 0);
    exp_q.delete();
    exp_cnt = '0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    push(32'h40435293, 32'h0, 32'hF0000000, 32'h0,
         pk(32'hF0000000, 32'd4, 4'b1010, 5'd5, 1, 0, 3'b101, 0));
    wait_drain();
    check("post_rst_count", issue_count, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
